// File: rtl/imem_bridge.sv
// imem_bridge: credit-limited instruction-fetch bridge with an in-order response queue.
// Optional PC-redirect squash support is compiled in with `define IMEM_BRIDGE_SQUASH_EN.
module imem_bridge #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IMEM_BRIDGE_SQUASH_EN
  input  logic        squash,
`endif
  input  logic        preq_val,
  input  logic [31:0] preq_addr,
  output logic        preq_rdy,
  output logic        presp_val,
  output logic [31:0] presp_data,
  input  logic        presp_rdy,
  output logic        mreq_val,
  output logic [31:0] mreq_addr,
  input  logic        mreq_rdy,
  input  logic        mresp_val,
  input  logic [31:0] mresp_data,
  output logic        err
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] out_q, out_d, cnt_q, cnt_d, infl;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   mem_q [QDEPTH];
  logic          err_q, err_d;
  logic          consume, credit, fire, bad, disc, enq, sq, dropping;
`ifdef IMEM_BRIDGE_SQUASH_EN
  logic [CW-1:0] drop_q, drop_d, drop_load;
  assign sq        = squash;
  assign dropping  = drop_q != '0;
  assign drop_load = infl - CW'(mresp_val && !bad);
  assign drop_d    = sq ? drop_load : drop_q - CW'(disc);
`else
  assign sq       = 1'b0;
  assign dropping = 1'b0;
`endif
  // In-flight excludes words already sitting in the queue; a response with none in flight is illegal.
  assign infl       = out_q - cnt_q;
  assign presp_val  = cnt_q != '0;
  assign presp_data = presp_val ? mem_q[rd_q] : '0;
  assign consume    = presp_val && presp_rdy;
  assign credit     = rst && (out_q < CW'(QDEPTH) || consume) && !sq;
  assign mreq_val   = preq_val && credit;
  assign preq_rdy   = mreq_rdy && credit;
  assign mreq_addr  = preq_addr;
  assign fire       = mreq_val && mreq_rdy;
  assign bad        = mresp_val && infl == '0;
  assign disc       = mresp_val && !bad && dropping;
  assign enq        = mresp_val && !bad && !dropping && !sq;
  assign err        = err_q;
  always_comb begin
    err_d = err_q || bad;
`ifdef IMEM_BRIDGE_SQUASH_EN
    out_d = sq ? drop_load : out_q + CW'(fire) - CW'(consume) - CW'(disc);
`else
    out_d = out_q + CW'(fire) - CW'(consume) - CW'(disc);
`endif
    cnt_d = sq ? '0 : cnt_q + CW'(enq) - CW'(consume);
    wr_d  = sq ? '0 : wr_q + AW'(enq);
    rd_d  = sq ? '0 : rd_q + AW'(consume);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
`ifdef IMEM_BRIDGE_SQUASH_EN
      drop_q <= '0;
`endif
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      err_q <= err_d;
`ifdef IMEM_BRIDGE_SQUASH_EN
      drop_q <= drop_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q] <= mresp_data;
  end
endmodule

// File: tb/tb_imem_bridge.sv
// tb_imem_bridge: directed stimulus plus a queue-based reference model compared every cycle.
module tb_imem_bridge;
  localparam int QD = 2;
  logic        clk = 1'b0, rst = 1'b0, sq_v = 1'b0;
  logic        preq_val = 0, presp_rdy = 0, mreq_rdy = 0, mresp_val = 0;
  logic [31:0] preq_addr = '0, mresp_data = '0;
  logic        preq_rdy, presp_val, mreq_val, err;
  logic [31:0] presp_data, mreq_addr;
  int errors = 0, checks = 0;
  logic [31:0] mq[$];
  int m_out = 0, m_drop = 0;
  bit m_err = 0;

  imem_bridge #(.QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
`ifdef IMEM_BRIDGE_SQUASH_EN
    .squash(sq_v),
`endif
    .preq_val(preq_val), .preq_addr(preq_addr), .preq_rdy(preq_rdy),
    .presp_val(presp_val), .presp_data(presp_data), .presp_rdy(presp_rdy),
    .mreq_val(mreq_val), .mreq_addr(mreq_addr), .mreq_rdy(mreq_rdy),
    .mresp_val(mresp_val), .mresp_data(mresp_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: outstanding count, FIFO of words, pending drops.
  always @(posedge clk or negedge rst) begin
    int infl;
    bit cons, fire;
    if (!rst) begin
      mq.delete();
      m_out = 0;
      m_drop = 0;
      m_err = 0;
    end else begin
      infl = m_out - mq.size();
      cons = mq.size() > 0 && presp_rdy;
      fire = preq_val && mreq_rdy && !sq_v && (m_out < QD || cons);
      if (mresp_val && infl == 0) m_err = 1;
      if (sq_v) begin
        mq.delete();
        m_drop = infl - ((mresp_val && infl > 0) ? 1 : 0);
        m_out = m_drop;
      end else begin
        if (mresp_val && infl > 0) begin
          if (m_drop > 0) begin
            m_drop--;
            m_out--;
          end else mq.push_back(mresp_data);
        end
        if (cons) begin
          void'(mq.pop_front());
          m_out--;
        end
        if (fire) m_out++;
      end
    end
  end

  always @(negedge clk) begin
    bit cred, evld;
    evld = mq.size() > 0;
    cred = rst && !sq_v && (m_out < QD || (evld && presp_rdy));
    chk("mreq_val", {31'b0, mreq_val}, {31'b0, preq_val && cred});
    chk("preq_rdy", {31'b0, preq_rdy}, {31'b0, mreq_rdy && cred});
    chk("mreq_addr", mreq_addr, preq_addr);
    chk("presp_val", {31'b0, presp_val}, {31'b0, evld});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (evld) chk("presp_data", presp_data, mq[0]);
  end

  task automatic drv(input logic pv, input logic [31:0] pa, input logic pr,
                     input logic mr, input logic mv, input logic [31:0] md);
    preq_val = pv; preq_addr = pa; presp_rdy = pr;
    mreq_rdy = mr; mresp_val = mv; mresp_data = md;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour and a late response right after reset release
    drv(1, 32'h4, 0, 1, 1, 32'h55);
    chk("rst_mreq_val", {31'b0, mreq_val}, 32'd0);
    chk("rst_presp_val", {31'b0, presp_val}, 32'd0);
    chk("rst_presp_data", presp_data, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    tick();
    chk("rst_err_hold", {31'b0, err}, 32'd0);
    rst = 1'b1;
    drv(0, 0, 0, 1, 1, 32'h55);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("late_err", {31'b0, err}, 32'd1);
    chk("late_presp_val", {31'b0, presp_val}, 32'd0);
    do_reset();
    chk("reset_clears_err", {31'b0, err}, 32'd0);
    // Single fetch round trip
    drv(1, 32'h0, 1, 1, 0, 0);
    chk("t1_mreq_val", {31'b0, mreq_val}, 32'd1);
    chk("t1_mreq_addr", mreq_addr, 32'h0);
    tick();
    drv(0, 0, 1, 1, 1, 32'h13);
    tick();
    drv(0, 0, 1, 1, 0, 0);
    chk("t1_presp_val", {31'b0, presp_val}, 32'd1);
    chk("t1_presp_data", presp_data, 32'h13);
    chk("t1_err", {31'b0, err}, 32'd0);
    tick();
    chk("t1_drained", {31'b0, presp_val}, 32'd0);
    // Credit exhaustion then simultaneous consume and fire
    drv(1, 32'h4, 0, 1, 0, 0);
    tick();
    drv(1, 32'h8, 0, 1, 0, 0);
    tick();
    drv(1, 32'hC, 0, 1, 0, 0);
    chk("t2_preq_rdy", {31'b0, preq_rdy}, 32'd0);
    chk("t2_mreq_val", {31'b0, mreq_val}, 32'd0);
    tick();
    drv(1, 32'hC, 0, 1, 1, 32'hA0);
    tick();
    drv(1, 32'hC, 0, 1, 1, 32'hA1);
    tick();
    drv(1, 32'hC, 0, 1, 0, 0);
    chk("t2_still_blocked", {31'b0, mreq_val}, 32'd0);
    chk("t2_head", presp_data, 32'hA0);
    drv(1, 32'h8, 1, 1, 0, 0);
    chk("t3_mreq_val", {31'b0, mreq_val}, 32'd1);
    chk("t3_mreq_addr", mreq_addr, 32'h8);
    chk("t3_preq_rdy", {31'b0, preq_rdy}, 32'd1);
    tick();
    drv(1, 32'hC, 0, 1, 0, 0);
    chk("t3_out_stays_full", {31'b0, mreq_val}, 32'd0);
    chk("t3_next_head", presp_data, 32'hA1);
    drv(0, 0, 1, 1, 1, 32'hA2);
    tick();
    drv(0, 0, 1, 1, 0, 0);
    chk("t3_enq_deq", presp_data, 32'hA2);
    tick();
    chk("t3_drained", {31'b0, presp_val}, 32'd0);
    // Unsolicited response
    drv(0, 0, 0, 1, 1, 32'hDEAD);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("t4_err", {31'b0, err}, 32'd1);
    chk("t4_presp_val", {31'b0, presp_val}, 32'd0);
    repeat (3) tick();
    chk("t4_err_sticky", {31'b0, err}, 32'd1);
    // Reset mid-stream
    do_reset();
    drv(1, 32'h20, 0, 1, 0, 0);
    tick();
    drv(1, 32'h24, 0, 1, 0, 0);
    tick();
    drv(0, 0, 0, 1, 1, 32'h77);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("t6_queued", {31'b0, presp_val}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_presp_val", {31'b0, presp_val}, 32'd0);
    chk("t6_async_presp_data", presp_data, 32'd0);
    tick();
    rst = 1'b1;
    drv(0, 0, 0, 1, 1, 32'h88);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    chk("t6_late_err", {31'b0, err}, 32'd1);
`ifdef IMEM_BRIDGE_SQUASH_EN
    // Squash with two fetches in flight
    do_reset();
    drv(1, 32'h40, 0, 1, 0, 0);
    tick();
    drv(1, 32'h44, 0, 1, 0, 0);
    tick();
    sq_v = 1'b1;
    drv(1, 32'h48, 0, 1, 0, 0);
    chk("t5_sq_preq_rdy", {31'b0, preq_rdy}, 32'd0);
    chk("t5_sq_mreq_val", {31'b0, mreq_val}, 32'd0);
    tick();
    sq_v = 1'b0;
    drv(0, 0, 1, 1, 1, 32'hAAAA0000);
    tick();
    drv(0, 0, 1, 1, 1, 32'hBBBB0000);
    tick();
    drv(0, 0, 1, 1, 0, 0);
    chk("t5_dropped", {31'b0, presp_val}, 32'd0);
    chk("t5_no_err", {31'b0, err}, 32'd0);
    drv(1, 32'h100, 1, 1, 0, 0);
    chk("t5_refetch", {31'b0, mreq_val}, 32'd1);
    tick();
    drv(0, 0, 0, 1, 1, 32'h12345678);
    tick();
    drv(0, 0, 1, 1, 0, 0);
    chk("t5_delivered_val", {31'b0, presp_val}, 32'd1);
    chk("t5_delivered_data", presp_data, 32'h12345678);
    tick();
`endif
    // Mixed traffic exercising pointer wrap; responses only when something is in flight
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drv(i % 4 != 3, 32'h1000 + 32'(i) * 4, i % 5 < 3, i % 7 != 0,
          (i % 2 == 0) && (m_out - mq.size()) > 0, 32'hC0DE0000 + 32'(i));
      tick();
    end
    drv(0, 0, 1, 1, 0, 0);
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
